// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and cache-side signal bundle for the MEM-stage load/store sequencer.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);

  // Pipeline request
  logic              req_valid_i;
  logic              req_we_i;
  logic [2:0]        req_type_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;

  // Pipeline response
  logic              stall_o;
  logic              done_o;
  logic              misalign_o;
  logic [31:0]       load_data_o;

  // Data cache port
  logic              dc_req_o;
  logic              dc_we_o;
  logic [ADDR_W-1:0] dc_addr_o;
  logic [3:0]        dc_be_o;
  logic [31:0]       dc_wdata_o;
  logic              dc_ack_i;
  logic [31:0]       dc_rdata_i;

  // Performance counter
  logic [CNT_W-1:0]  slow_cnt_o;

  // Sequencer view
  modport slave (
    input  req_valid_i, req_we_i, req_type_i, req_addr_i, req_wdata_i,
    input  dc_ack_i, dc_rdata_i,
    output stall_o, done_o, misalign_o, load_data_o,
    output dc_req_o, dc_we_o, dc_addr_o, dc_be_o, dc_wdata_o,
    output slow_cnt_o
  );

  // Pipeline / cache environment view
  modport master (
    output req_valid_i, req_we_i, req_type_i, req_addr_i, req_wdata_i,
    output dc_ack_i, dc_rdata_i,
    input  stall_o, done_o, misalign_o, load_data_o,
    input  dc_req_o, dc_we_o, dc_addr_o, dc_be_o, dc_wdata_o,
    input  slow_cnt_o
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment check, cache handshake, load extension.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.slave   bus
);

  localparam int unsigned WAIT_W = 4;

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        lane_q;
  logic [2:0]        type_q;
  logic              we_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic              done_q;
  logic              misalign_q;
  logic [31:0]       load_data_q;
  logic              dc_req_q;
  logic              dc_we_q;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [3:0]        dc_be_q;
  logic [31:0]       dc_wdata_q;
  logic [CNT_W-1:0]  slow_cnt_q;

  logic              bad_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       shifted_c;
  logic [31:0]       ext_c;

  // Decode the incoming op: legality/alignment, byte enables, lane-replicated store data
  always_comb begin
    bad_c   = 1'b1;
    be_c    = 4'b1111;
    wdata_c = 32'h0;
    case (bus.req_type_i)
      T_B: begin
        bad_c = 1'b0;
        if (bus.req_we_i) begin
          be_c    = 4'b0001 << bus.req_addr_i[1:0];
          wdata_c = {4{bus.req_wdata_i[7:0]}};
        end
      end
      T_H: begin
        bad_c = bus.req_addr_i[0];
        if (bus.req_we_i) begin
          be_c    = 4'b0011 << bus.req_addr_i[1:0];
          wdata_c = {2{bus.req_wdata_i[15:0]}};
        end
      end
      T_W: begin
        bad_c = (bus.req_addr_i[1:0] != 2'b00);
        if (bus.req_we_i) begin
          wdata_c = bus.req_wdata_i;
        end
      end
      T_BU:    bad_c = bus.req_we_i;
      T_HU:    bad_c = bus.req_we_i | bus.req_addr_i[0];
      default: bad_c = 1'b1;
    endcase
  end

  // Align the returned word to the addressed lane and extend to 32 bits
  always_comb begin
    shifted_c = bus.dc_rdata_i >> {lane_q, 3'b000};
    case (type_q)
      T_B:     ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      T_BU:    ext_c = {24'h0, shifted_c[7:0]};
      T_H:     ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      T_HU:    ext_c = {16'h0, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

  // Sequencer FSM with registered outputs and slow-access accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lane_q      <= 2'b00;
      type_q      <= 3'b000;
      we_q        <= 1'b0;
      wait_cnt    <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      load_data_q <= 32'h0;
      dc_req_q    <= 1'b0;
      dc_we_q     <= 1'b0;
      dc_addr_q   <= '0;
      dc_be_q     <= 4'b0000;
      dc_wdata_q  <= 32'h0;
      slow_cnt_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      load_data_q <= 32'h0;
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            lane_q <= bus.req_addr_i[1:0];
            type_q <= bus.req_type_i;
            we_q   <= bus.req_we_i;
            if (bad_c) begin
              // Illegal or misaligned: complete without touching the cache
              state      <= RESP;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state      <= REQ;
              dc_req_q   <= 1'b1;
              dc_we_q    <= bus.req_we_i;
              dc_addr_q  <= {bus.req_addr_i[ADDR_W-1:2], 2'b00};
              dc_be_q    <= be_c;
              dc_wdata_q <= wdata_c;
              wait_cnt   <= '0;
            end
          end
        end
        REQ: begin
          if (bus.dc_ack_i) begin
            state    <= RESP;
            dc_req_q <= 1'b0;
            done_q   <= 1'b1;
            if (!we_q) begin
              load_data_q <= ext_c;
            end
            if ((wait_cnt != '0) && (slow_cnt_q != '1)) begin
              slow_cnt_q <= slow_cnt_q + CNT_W'(1);
            end
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RESP: begin
          // Same instruction still presents req_valid here; never relaunch it
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_o     = bus.req_valid_i & ~done_q;
  assign bus.done_o      = done_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.load_data_o = load_data_q;
  assign bus.dc_req_o    = dc_req_q;
  assign bus.dc_we_o     = dc_we_q;
  assign bus.dc_addr_o   = dc_addr_q;
  assign bus.dc_be_o     = dc_be_q;
  assign bus.dc_wdata_o  = dc_wdata_q;
  assign bus.slow_cnt_o  = slow_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a behavioural model.
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;
  longint slow_model;

  mem_access_ctrl_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural model of one access: legality, bus image and extended load value
  function automatic void model(input logic we, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] rd,
                                output logic mis, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int size;
    logic sgn;
    int lane;
    longint v;
    longint mask;
    size = 0;
    sgn  = 1'b0;
    case (t)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; sgn = 1'b0; end
      3'd4: begin size = 1; sgn = 1'b0; end
      3'd5: begin size = 2; sgn = 1'b0; end
      default: size = 0;
    endcase
    lane = int'(a % 4);
    mis  = (size == 0) || (we && t[2]) || ((a % size) != 0);
    be   = 4'hF;
    wd   = 32'h0;
    ld   = 32'h0;
    if (mis) return;
    if (we) begin
      be = 4'(((1 << size) - 1) << lane);
      case (size)
        1:       wd = 32'(d[7:0]) * 32'h0101_0101;
        2:       wd = 32'(d[15:0]) * 32'h0001_0001;
        default: wd = d;
      endcase
    end else begin
      mask = (64'sd1 <<< (8 * size)) - 1;
      v = (longint'(rd) >>> (8 * lane)) & mask;
      if (sgn && (v >= (mask + 1) / 2)) v = v - (mask + 1);
      ld = 32'(v);
    end
  endfunction

  // Drive one op starting at a negedge in IDLE; ends at the negedge of the following IDLE cycle
  task automatic run_op(input logic we, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int waits);
    logic mis;
    logic [3:0] be;
    logic [31:0] wd;
    logic [31:0] ld;
    int done_k;
    logic exp_req;
    model(we, t, a, d, rd, mis, be, wd, ld);
    done_k = mis ? 1 : 2 + waits;
    if (!mis && waits >= 1) slow_model++;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_type_i  = t;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    bus.dc_ack_i    = 1'($urandom_range(0, 1));
    bus.dc_rdata_i  = $urandom;
    #1;
    check("accept_req", 64'(bus.dc_req_o), 64'(0));
    check("accept_done", 64'(bus.done_o), 64'(0));
    check("accept_stall", 64'(bus.stall_o), 64'(1));
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      exp_req = !mis && (k <= 1 + waits);
      check("dc_req", 64'(bus.dc_req_o), 64'(exp_req));
      check("done", 64'(bus.done_o), 64'(k == done_k));
      check("misalign", 64'(bus.misalign_o), 64'(mis && (k == done_k)));
      check("stall", 64'(bus.stall_o), 64'(k != done_k));
      if (exp_req) begin
        check("dc_addr", 64'(bus.dc_addr_o), 64'(a & 32'hFFFF_FFFC));
        check("dc_we", 64'(bus.dc_we_o), 64'(we));
        check("dc_be", 64'(bus.dc_be_o), 64'(be));
        if (we) check("dc_wdata", 64'(bus.dc_wdata_o), 64'(wd));
      end
      if (k == done_k) begin
        check("load_data", 64'(bus.load_data_o), 64'(ld));
        check("slow_cnt", 64'(bus.slow_cnt_o), 64'(slow_model));
      end
      bus.dc_ack_i   = exp_req && (k == 1 + waits);
      bus.dc_rdata_i = bus.dc_ack_i ? rd : $urandom;
    end
    @(negedge clk);
  endtask

  // Idle cycles with a noisy ack line that must be ignored
  task automatic idle_gap(input int n);
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.dc_ack_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("gap_req", 64'(bus.dc_req_o), 64'(0));
      check("gap_done", 64'(bus.done_o), 64'(0));
      check("gap_stall", 64'(bus.stall_o), 64'(0));
    end
    bus.dc_ack_i = 1'b0;
  endtask

  initial begin
    logic [2:0] types [8];
    n_tests    = 0;
    n_fail     = 0;
    slow_model = 0;
    types[0] = 3'd0; types[1] = 3'd1; types[2] = 3'd2; types[3] = 3'd4;
    types[4] = 3'd5; types[5] = 3'd3; types[6] = 3'd6; types[7] = 3'd7;

    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_type_i  = 3'd0;
    bus.req_addr_i  = 32'h0;
    bus.req_wdata_i = 32'h0;
    bus.dc_ack_i    = 1'b0;
    bus.dc_rdata_i  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(bus.dc_req_o), 64'(0));
    check("rst_done", 64'(bus.done_o), 64'(0));
    check("rst_misalign", 64'(bus.misalign_o), 64'(0));
    check("rst_load", 64'(bus.load_data_o), 64'(0));
    check("rst_be", 64'(bus.dc_be_o), 64'(0));
    check("rst_addr", 64'(bus.dc_addr_o), 64'(0));
    check("rst_slow", 64'(bus.slow_cnt_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 0);
    run_op(1'b0, 3'd5, 32'h2002, 32'h0, 32'hBEEF_0000, 3);
    run_op(1'b1, 3'd0, 32'h0011, 32'h0000_00A5, $urandom, 0);
    run_op(1'b0, 3'd2, 32'h0006, 32'h0, $urandom, 0);
    run_op(1'b1, 3'd1, 32'h0003, 32'h1234, $urandom, 0);
    run_op(1'b1, 3'd4, 32'h0008, 32'h55, $urandom, 0);
    run_op(1'b0, 3'd3, 32'h0008, 32'h0, $urandom, 0);
    idle_gap(2);

    // Reset while waiting for the cache
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_type_i  = 3'd2;
    bus.req_addr_i  = 32'h40;
    bus.dc_ack_i    = 1'b0;
    @(negedge clk);
    check("rstreq_req", 64'(bus.dc_req_o), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    slow_model = 0;
    #1;
    check("rstreq_drop", 64'(bus.dc_req_o), 64'(0));
    check("rstreq_done", 64'(bus.done_o), 64'(0));
    check("rstreq_slow", 64'(bus.slow_cnt_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.dc_ack_i    = 1'b1;
    bus.dc_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late_ack_done", 64'(bus.done_o), 64'(0));
    check("late_ack_req", 64'(bus.dc_req_o), 64'(0));
    bus.dc_ack_i = 1'b0;
    @(negedge clk);
    check("late_ack_done2", 64'(bus.done_o), 64'(0));
    check("late_ack_load", 64'(bus.load_data_o), 64'(0));

    // Back-to-back loads
    run_op(1'b0, 3'd2, 32'h0, 32'h0, 32'h1122_3344, 0);
    run_op(1'b0, 3'd1, 32'h4, 32'h0, 32'h0000_8001, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 3));
      run_op(1'($urandom_range(0, 1)), types[$urandom_range(0, 7)], a,
             $urandom, $urandom, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage load/store sequencer between the pipeline and the data cache port. Accepts one memory operation at a time and checks alignment. Builds the word-aligned address, byte enables and lane-replicated store data. Runs the request/acknowledge handshake with the cache, stalls the pipeline until completion, then returns sign/zero-extended load data.

Parameters:
ADDR_W, 32, byte address width
CNT_W, 32, width of the slow-access performance counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  1  memory op present in MEM stage; held stable until done_o
req_we_i  input  1  1 = store, 0 = load
req_type_i  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
req_addr_i  input  ADDR_W  byte address
req_wdata_i  input  32  store data, right-aligned
stall_o  output  1  pipeline hold
done_o  output  1  one-cycle completion pulse
misalign_o  output  1  one-cycle pulse with done_o on a misaligned access
load_data_o  output  32  extended load result, valid with done_o
dc_req_o  output  1  cache request
dc_we_o  output  1  cache write
dc_addr_o  output  ADDR_W  word-aligned address, low 2 bits zero
dc_be_o  output  4  byte enables
dc_wdata_o  output  32  lane-replicated store data
dc_ack_i  input  1  cache acknowledge; carries dc_rdata_i for loads
dc_rdata_i  input  32  aligned read word
slow_cnt_o  output  CNT_W  count of accesses whose ack arrived more than 1 cycle after first dc_req_o

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, slow_cnt_o = 0. Reset is asynchronous: asserting rst_n low mid-operation drops dc_req_o immediately and returns the FSM to IDLE.
- stall_o = req_valid_i & ~done_o (combinational).
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On req_valid_i, latch addr, type, we and wdata.
  - If misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0): go to RESP with misalign flag set and no cache request.
  - Otherwise go to REQ.
  - dc_ack_i is ignored in IDLE.
- REQ:
  - dc_req_o = 1; dc_addr_o, dc_we_o, dc_be_o and dc_wdata_o are held stable from registers.
  - On dc_ack_i: capture dc_rdata_i and go to RESP.
  - An internal wait counter increments every REQ cycle without ack. If ack arrives with wait count >= 1, slow_cnt_o increments, saturating at all-ones.
- RESP:
  - done_o = 1, dc_req_o = 0, load_data_o is registered. Next state is IDLE unconditionally.
  - The still-high req_valid_i in this cycle (same instruction) must not relaunch.
- Store byte enables and data:
  - B: be = 0001 << addr[1:0], wdata = {4{d[7:0]}}.
  - H: be = 0011 << addr[1:0], wdata = {2{d[15:0]}}.
  - W: be = 1111, wdata = d.
  - Loads: be = 1111.
- Load extension: shift the captured word right by addr[1:0]*8.
  - B: sign-extend bit 7. BU: zero-extend 8 bits.
  - H: sign-extend bit 15. HU: zero-extend 16 bits.
  - W: word unchanged.
  - Stores and misaligned accesses: load_data_o = 0.
- Undefined req_type_i (011, 110, 111, or BU/HU on a store): treated as misaligned (misalign_o pulse, no cache access).
- Latency: a 0-wait ack gives done_o 2 cycles after acceptance in IDLE. Each extra ack wait cycle adds 1. Misaligned accesses take 1 cycle (IDLE→RESP).
- Back-to-back: a new request in the cycle after RESP is accepted normally.

Test Plan:
- Load LB addr 0x1003, ack immediately with rdata 0x80FF_1234 -> dc_addr_o=0x1000, dc_be_o=1111, done_o 2 cycles after accept, load_data_o=0xFFFF_FF80, slow_cnt_o stays 0.
- Load LHU addr 0x2002, ack after 3 wait cycles with rdata 0xBEEF_0000 -> stall_o high throughout, load_data_o=0x0000_BEEF, slow_cnt_o=1.
- Store SB addr 0x10 lane 1 (addr 0x11), data 0x0000_00A5 -> dc_we_o=1, dc_be_o=0010, dc_wdata_o=0xA5A5_A5A5, load_data_o=0.
- Load LW addr 0x06 -> no dc_req_o, misalign_o and done_o pulse together 1 cycle after accept; SH addr 0x03 behaves the same.
- Assert rst_n low while in REQ, then release; a late dc_ack_i arrives -> dc_req_o falls immediately, FSM in IDLE, ack ignored, no done_o.
- Two back-to-back loads, LW 0x0 then LH 0x4, with 0-wait acks -> two done_o pulses exactly 3 cycles apart, no duplicate cache request.
